fifo_stream_reader: RTL

- Read-side drain engine for sync_fifo. It issues pops on the FIFO read port, absorbs the FIFO's one-cycle registered read latency, and presents the data downstream as a valid/ready stream.
- A 2-entry prefetch/skid buffer sustains one word per cycle under continuous ready and never loses data when ready drops.
- Sits between sync_fifo and any consumer (DMA, serializer, packetizer).

---
 rtl/fifo_stream_reader_if.sv | 22 ++
 rtl/fifo_stream_reader.sv | 117 +++++++++++
 2 files changed

// File: rtl/fifo_stream_reader_if.sv
// Signal bundle between the reader, the sync_fifo read port and the downstream stream.
// The reader takes the master modport; the FIFO/consumer side takes the slave modport.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  i_fifo_empty;
   logic [DATA_WIDTH-1:0] i_fifo_rd_data;
   logic                  o_fifo_rd_en;
   logic                  o_valid;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] o_data;

   modport master (
      input  i_fifo_empty, i_fifo_rd_data, i_ready,
      output o_fifo_rd_en, o_valid, o_data
   );

   modport slave (
      output i_fifo_empty, i_fifo_rd_data, i_ready,
      input  o_fifo_rd_en, o_valid, o_data
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a sync_fifo with one-cycle read latency into a valid/ready stream.
// A two-entry skid buffer keeps one word per cycle flowing under continuous ready.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_en,
   input  logic                  i_flush,
   fifo_stream_reader_if.master  io_bus,
   output logic [1:0]            o_buf_count,
   output logic [CNT_WIDTH-1:0]  o_xfer_count,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   buf_state_e            r_state;
   buf_state_e            w_state_nxt;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   logic [DATA_WIDTH-1:0] w_head_nxt;
   logic [DATA_WIDTH-1:0] w_tail_nxt;
   logic                  r_inflight;
   logic [CNT_WIDTH-1:0]  r_xfer;
   logic                  w_valid;
   logic                  w_pop_out;
   logic                  w_arrive;
   logic                  w_rd_en;
   logic [2:0]            w_occupancy;

   assign w_valid   = (r_state != BUF_EMPTY);
   assign w_pop_out = w_valid & io_bus.i_ready;
   // A word returning during a flush cycle is dropped rather than buffered.
   assign w_arrive  = r_inflight & ~i_flush;

   // Counting the word leaving this cycle lets a pop issue into a slot that frees at the same edge.
   assign w_occupancy = {1'b0, r_state} + {2'b00, r_inflight} - {2'b00, w_pop_out};
   assign w_rd_en     = i_rstn & i_en & ~i_flush & ~io_bus.i_fifo_empty & (w_occupancy < 3'd2);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state    <= BUF_EMPTY;
         // NOTE: the data registers are reset because o_data must read 0 out of reset.
         r_head     <= '0;
         r_tail     <= '0;
         r_inflight <= 1'b0;
         r_xfer     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state    <= w_state_nxt;
         r_head     <= w_head_nxt;
         r_tail     <= w_tail_nxt;
         r_inflight <= w_rd_en;
         r_xfer     <= r_xfer + CNT_WIDTH'(w_pop_out);
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case infers a latch.
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      if (i_flush) begin
         w_state_nxt = BUF_EMPTY;
      end else begin
         case (r_state)
            BUF_EMPTY: begin
               if (w_arrive) begin
                  w_state_nxt = BUF_ONE;
                  w_head_nxt  = io_bus.i_fifo_rd_data;
               end
            end
            BUF_ONE: begin
               if (w_arrive && w_pop_out) begin
                  w_head_nxt = io_bus.i_fifo_rd_data;
               end else if (w_arrive) begin
                  w_state_nxt = BUF_TWO;
                  w_tail_nxt  = io_bus.i_fifo_rd_data;
               end else if (w_pop_out) begin
                  w_state_nxt = BUF_EMPTY;
               end
            end
            BUF_TWO: begin
               if (w_pop_out) begin
                  w_head_nxt = r_tail;
                  if (w_arrive) begin
                     w_tail_nxt = io_bus.i_fifo_rd_data;
                  end else begin
                     w_state_nxt = BUF_ONE;
                  end
               end
            end
            default: w_state_nxt = BUF_EMPTY;
         endcase
      end
   end

   assign io_bus.o_fifo_rd_en = w_rd_en;
   assign io_bus.o_valid      = w_valid;
   assign io_bus.o_data       = r_head;
   assign o_buf_count         = r_state;
   assign o_xfer_count        = r_xfer;
   assign o_busy              = w_valid | r_inflight;

   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
      !((r_state == BUF_TWO) && w_arrive && !w_pop_out));

   a_no_pop_when_empty: assert property (@(posedge i_clk) disable iff (!i_rstn)
      !(w_rd_en && io_bus.i_fifo_empty));

endmodule
